downsample: RTL and testbench
=============================

// Module: downsample
// PURPOSE
//   Receive-side decimator for the I/Q sample path: the inverse of the 8x upsampler.
//   Takes a fast-rate sin/cos stream qualified by input_val and averages each group of
//   2**RATIO_LOG2 valid samples (boxcar, round-half-up). Emits one decimated sin/cos pair
//   per group with a single-cycle val strobe. Feeds the slow-rate DSP/capture logic.
// PARAMETERS
//   DATA_W     16  sample width, signed two's complement, in and out
//   RATIO_LOG2 3   log2 of decimation ratio (3 -> average 8 samples)
// PORTS
//   clk        in   1       single system clock, all logic rising-edge
//   rst        in   1       asynchronous, active-high reset
//   sin_in     in   DATA_W  signed sin (I) input sample
//   cos_in     in   DATA_W  signed cos (Q) input sample
//   input_val  in   1       sin_in/cos_in valid this cycle
//   phase_clr  in   1       synchronous group restart (realign decimation phase)
//   sin_out    out  DATA_W  averaged sin sample, held between strobes
//   cos_out    out  DATA_W  averaged cos sample, held between strobes
//   val        out  1       1-cycle strobe: sin_out/cos_out updated this cycle
// BEHAVIOUR
//   - Reset (async assert): cnt=0, both accumulators=0, sin_out=cos_out=0, val=0.
//   - Accumulators ACC_W = DATA_W+RATIO_LOG2 bits signed; inputs sign-extended; no overflow.
//   - cnt (RATIO_LOG2 bits) counts valid samples in the current group; states = cnt values
//     0..N-1 (N=2**RATIO_LOG2); cnt=0 is the group-start state.
//   - input_val=1, cnt<N-1: acc <= (cnt==0 ? 0 : acc) + in; cnt <= cnt+1; val=0.
//   - input_val=1, cnt==N-1: sum = acc + in; out <= (sum + 2**(RATIO_LOG2-1)) >>> RATIO_LOG2,
//     truncated to DATA_W (result is provably in range); val <= 1; cnt <= 0.
//   - Latency: out/val registered 1 cycle after the clock edge sampling the Nth valid input.
//   - input_val=0: cnt, acc, outputs hold; val <= 0. Gaps of any length allowed within a group.
//   - val never high 2 consecutive cycles unless N valid inputs arrived; max 1 strobe per N inputs.
//   - sin and cos share cnt; they are always decimated in lock-step.
//   - phase_clr=1, input_val=0: cnt <= 0, acc <= 0; partial group discarded; no strobe;
//     outputs hold last value.
//   - phase_clr=1 with input_val=1: partial group discarded; the current sample becomes
//     sample 0 of a new group (acc <= in, cnt <= 1); no strobe, even if cnt was N-1.
//   - Reset asserted mid-group: partial group lost, all state as above; first strobe after
//     release needs N fresh valid inputs.
//   - RATIO_LOG2=0 is unsupported (elaboration error); RATIO_LOG2 >= 1 required.
// TESTING
//   1 sin=100, cos=-100, input_val=1 for 8 cycles -> one val pulse, sin_out=100, cos_out=-100.
//   2 sin=0..7 ramp, cos=-1 x8 -> sin_out=4 ((28+4)>>>3), cos_out=-1 ((-8+4)>>>3).
//   3 full scale: sin=32767 x8, cos=-32768 x8 -> sin_out=32767, cos_out=-32768, no wrap.
//   4 8 valid samples of 50 spread over 20 cycles with random gaps -> exactly one val,
//     1 cycle after the 8th valid; sin_out=50; outputs hold afterwards.
//   5 5 samples of 1000, phase_clr+input_val with 200, 7 more 200 -> single strobe, sin_out=200.
//   6 rst pulsed after 4 samples -> outputs 0, val 0; next 8 samples of -7 -> sin_out=-7
//     ((-56+4)>>>3 = -7); continuous 64-sample stream -> exactly 8 strobes, 8 cycles apart.

Source files
------------

// File: rtl/downsample.sv
// downsample: receive-side I/Q boxcar decimator.
//   Averages each group of 2**RATIO_LOG2 valid sin/cos samples (round-half-up)
//   and emits one decimated pair per group with a single-cycle strobe.
// Ports:
//   clk        - system clock, rising-edge
//   rst        - asynchronous active-high reset
//   sin_in     - signed sin (I) input sample
//   cos_in     - signed cos (Q) input sample
//   input_val  - sin_in/cos_in valid this cycle
//   phase_clr  - synchronous group restart (realigns decimation phase)
//   sin_out    - averaged sin sample, held between strobes
//   cos_out    - averaged cos sample, held between strobes
//   val        - 1-cycle strobe: sin_out/cos_out updated this cycle
module downsample #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RATIO_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sin_in,
  input  logic [DATA_W-1:0] cos_in,
  input  logic              input_val,
  input  logic              phase_clr,
  output logic [DATA_W-1:0] sin_out,
  output logic [DATA_W-1:0] cos_out,
  output logic              val
);

  generate
    if (RATIO_LOG2 < 1) begin : g_ratio_chk
      $error("downsample: RATIO_LOG2 must be >= 1");
    end
  endgenerate

  localparam int unsigned ACC_W = DATA_W + RATIO_LOG2;
  localparam logic [RATIO_LOG2-1:0] CNT_LAST = '1;
  localparam logic [RATIO_LOG2-1:0] CNT_ONE  = RATIO_LOG2'(1);

  logic [RATIO_LOG2-1:0] cnt_q;
  logic [ACC_W-1:0]      sin_acc_q, cos_acc_q;
  logic [DATA_W-1:0]     sin_out_q, cos_out_q;
  logic                  val_q;

  logic [ACC_W-1:0]      sin_ext, cos_ext;
  logic [ACC_W-1:0]      sin_sum, cos_sum;
  logic [DATA_W-1:0]     sin_avg_d, cos_avg_d;

  always_comb begin
    sin_ext = {{RATIO_LOG2{sin_in[DATA_W-1]}}, sin_in};
    cos_ext = {{RATIO_LOG2{cos_in[DATA_W-1]}}, cos_in};
    // cnt==0 starts a fresh group, so the stale accumulator is ignored.
    sin_sum = ((cnt_q == '0) ? '0 : sin_acc_q) + sin_ext;
    cos_sum = ((cnt_q == '0) ? '0 : cos_acc_q) + cos_ext;
    // (sum + 2**(R-1)) >>> R: adding half an LSB carries into the kept
    // bits exactly when bit R-1 of the sum is set.
    sin_avg_d = sin_sum[ACC_W-1:RATIO_LOG2]
              + {{(DATA_W-1){1'b0}}, sin_sum[RATIO_LOG2-1]};
    cos_avg_d = cos_sum[ACC_W-1:RATIO_LOG2]
              + {{(DATA_W-1){1'b0}}, cos_sum[RATIO_LOG2-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      sin_acc_q <= '0;
      cos_acc_q <= '0;
      sin_out_q <= '0;
      cos_out_q <= '0;
      val_q     <= 1'b0;
    end else begin
      val_q <= 1'b0;
      if (phase_clr) begin
        if (input_val) begin
          sin_acc_q <= sin_ext;
          cos_acc_q <= cos_ext;
          cnt_q     <= CNT_ONE;
        end else begin
          sin_acc_q <= '0;
          cos_acc_q <= '0;
          cnt_q     <= '0;
        end
      end else if (input_val) begin
        sin_acc_q <= sin_sum;
        cos_acc_q <= cos_sum;
        if (cnt_q == CNT_LAST) begin
          sin_out_q <= sin_avg_d;
          cos_out_q <= cos_avg_d;
          val_q     <= 1'b1;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign sin_out = sin_out_q;
  assign cos_out = cos_out_q;
  assign val     = val_q;

endmodule

// File: tb/tb_downsample.sv
module tb_downsample;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sin_in, cos_in;
  logic        input_val, phase_clr;
  logic [15:0] sin_out, cos_out;
  logic        val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] s;
    logic [15:0] c;
    logic        v;
    logic        clr;
    logic        ev;
    logic [15:0] es;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  downsample #(.DATA_W(16), .RATIO_LOG2(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin_in    (sin_in),
    .cos_in    (cos_in),
    .input_val (input_val),
    .phase_clr (phase_clr),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .val       (val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic add(input logic [15:0] s, input logic [15:0] c, input logic v,
                     input logic clr, input logic ev, input logic [15:0] es,
                     input logic [15:0] ec);
    vec_t r;
    r.s = s; r.c = c; r.v = v; r.clr = clr; r.ev = ev; r.es = es; r.ec = ec;
    vecs.push_back(r);
  endtask

  // Drive one cycle, then check the registered outputs just after the edge.
  task automatic step(input string nm, input logic [15:0] s, input logic [15:0] c,
                      input logic v, input logic clr, input logic ev,
                      input logic [15:0] es, input logic [15:0] ec);
    sin_in = s; cos_in = c; input_val = v; phase_clr = clr;
    @(posedge clk);
    #1;
    chk({nm, "_val"}, {15'b0, val}, {15'b0, ev});
    chk({nm, "_sin"}, sin_out, es);
    chk({nm, "_cos"}, cos_out, ec);
  endtask

  initial begin
    int pat;
    int vcnt;
    int strobes;
    logic [15:0] hs, hc;

    // Test 1: constant 100 / -100
    for (int i = 0; i < 8; i++)
      add(16'd100, -16'sd100, 1'b1, 1'b0, i == 7,
          (i == 7) ? 16'd100 : 16'd0, (i == 7) ? -16'sd100 : 16'd0);
    add(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd100, -16'sd100);
    // Test 2: ramp 0..7 -> 4, cos -1 -> -1
    for (int i = 0; i < 8; i++)
      add(16'(i), -16'sd1, 1'b1, 1'b0, i == 7,
          (i == 7) ? 16'd4 : 16'd100, (i == 7) ? -16'sd1 : -16'sd100);
    // Test 3: full scale, no wrap
    for (int i = 0; i < 8; i++)
      add(16'd32767, 16'h8000, 1'b1, 1'b0, i == 7,
          (i == 7) ? 16'd32767 : 16'd4, (i == 7) ? 16'h8000 : -16'sd1);
    // Rounding: sum -4 -> 0, sum 4 -> 1 (half rounds up)
    for (int i = 0; i < 8; i++)
      add((i < 4) ? -16'sd1 : 16'd0, (i == 0) ? 16'd4 : 16'd0, 1'b1, 1'b0, i == 7,
          (i == 7) ? 16'd0 : 16'd32767, (i == 7) ? 16'd1 : 16'h8000);

    rst = 1'b1; sin_in = '0; cos_in = '0; input_val = 1'b0; phase_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_val", {15'b0, val}, 16'd0);
    chk("reset_sin", sin_out, 16'd0);
    chk("reset_cos", cos_out, 16'd0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      step($sformatf("tbl%0d", k), vecs[k].s, vecs[k].c, vecs[k].v, vecs[k].clr,
           vecs[k].ev, vecs[k].es, vecs[k].ec);

    // Test 4: 8 valid samples spread over 20 cycles (bits 0,2,3,6,9,10,13,15)
    pat = 42573;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      logic v;
      v = ((pat >> i) & 1) == 1;
      if (v) vcnt++;
      step($sformatf("gap%0d", i), 16'd50, -16'sd50, v, 1'b0, v && (vcnt == 8),
           (vcnt == 8) ? 16'd50 : 16'd0, (vcnt == 8) ? -16'sd50 : 16'd1);
    end

    // Test 5: phase_clr with valid restarts the group
    for (int i = 0; i < 5; i++)
      step("clr_a", 16'd1000, -16'sd1000, 1'b1, 1'b0, 1'b0, 16'd50, -16'sd50);
    step("clr_b", 16'd200, -16'sd200, 1'b1, 1'b1, 1'b0, 16'd50, -16'sd50);
    for (int i = 0; i < 7; i++)
      step("clr_c", 16'd200, -16'sd200, 1'b1, 1'b0, i == 6,
           (i == 6) ? 16'd200 : 16'd50, (i == 6) ? -16'sd200 : -16'sd50);

    // phase_clr at cnt==N-1 suppresses the strobe; phase_clr alone discards
    for (int i = 0; i < 7; i++)
      step("clr_d", 16'd9, -16'sd9, 1'b1, 1'b0, 1'b0, 16'd200, -16'sd200);
    step("clr_e", 16'd16, -16'sd16, 1'b1, 1'b1, 1'b0, 16'd200, -16'sd200);
    step("clr_f", 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd200, -16'sd200);
    for (int i = 0; i < 8; i++)
      step("clr_g", 16'd16, -16'sd16, 1'b1, 1'b0, i == 7,
           (i == 7) ? 16'd16 : 16'd200, (i == 7) ? -16'sd16 : -16'sd200);

    // Test 6: reset mid-group
    for (int i = 0; i < 4; i++)
      step("pre_rst", 16'd3, 16'd3, 1'b1, 1'b0, 1'b0, 16'd16, -16'sd16);
    rst = 1'b1;
    #1;
    chk("rst_mid_val", {15'b0, val}, 16'd0);
    chk("rst_mid_sin", sin_out, 16'd0);
    chk("rst_mid_cos", cos_out, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      step("post_rst", -16'sd7, 16'd7, 1'b1, 1'b0, i == 7,
           (i == 7) ? -16'sd7 : 16'd0, (i == 7) ? 16'd7 : 16'd0);

    // Continuous 64-sample stream: group g averages to 8g+4 / -8g-3
    hs = -16'sd7; hc = 16'd7; strobes = 0;
    for (int k = 0; k < 64; k++) begin
      if (k % 8 == 7) begin
        hs = 16'(8 * (k / 8) + 4);
        hc = 16'(-(8 * (k / 8)) - 3);
      end
      step($sformatf("stream%0d", k), 16'(k), 16'(-k), 1'b1, 1'b0, (k % 8) == 7, hs, hc);
      if (val) strobes++;
    end
    step("stream_idle", 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, hs, hc);
    chk("stream_strobes", 16'(strobes), 16'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
